// File: rtl/rgb_layer_arbiter_pkg.sv
// Shared definitions for the RGB layer arbiter: stream field positions,
// widths and a small sizing helper. The stream layout is
// {R,G,B,x[9:0],y[9:0],hs,vs,av}, i.e. 26 bits, MSB first.
package rgb_layer_arbiter_pkg;

    // Stream geometry
    localparam int STREAM_W = 26;
    localparam int RGB_W    = 3;

    // Field positions inside the stream word
    localparam int R_POS    = 25;
    localparam int G_POS    = 24;
    localparam int B_POS    = 23;
    localparam int X_MSB    = 22;
    localparam int X_LSB    = 13;
    localparam int Y_MSB    = 12;
    localparam int Y_LSB    = 3;
    localparam int HS_POS   = 2;
    localparam int VS_POS   = 1;
    localparam int AV_POS   = 0;

    // Everything below the colour field passes through untouched
    localparam int META_W   = B_POS;

    // Index width for a one-hot-to-index selector; never zero so that a
    // single-layer build still has a legal vector.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rgb_prio_sel.sv
// Combinational lowest-index-wins selector. A layer competes only when it
// both requests the pixel and is enabled; valid is low when nobody does.
module rgb_prio_sel
    import rgb_layer_arbiter_pkg::*;
#(
    parameter int N_LAYERS = 4,
    parameter int IDX_W    = idx_width(N_LAYERS)
) (
    input  logic [N_LAYERS-1:0] req,
    input  logic [N_LAYERS-1:0] en,
    output logic [IDX_W-1:0]    idx,
    output logic                valid
);

    logic [N_LAYERS-1:0] live;

    assign live = req & en;

    // Scan from the lowest priority upward so the lowest live index is the
    // last assignment and therefore wins.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            if (live[i]) begin
                idx   = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rgb_layer_arbiter.sv
// RGB layer arbiter: overlays the colour of the highest-priority enabled
// layer onto a 26-bit pixel stream with a fixed one-cycle latency.
// Layer enables are shadowed and only take effect at the frame boundary
// (vsync inactive-to-active edge); frame_tick marks that boundary pixel on
// the output.
// Optional feature macro: RGB_LAYER_COLLISION_EN -- when defined, per-frame
// collisions of layers 1..N-1 against layer 0 are accumulated and reported
// on collide at each boundary; when undefined, collide is tied to zero.
module rgb_layer_arbiter
    import rgb_layer_arbiter_pkg::*;
#(
    parameter int               N_LAYERS = 4,
    parameter logic [RGB_W-1:0] BG_RGB   = 3'b000,
    parameter logic             VS_POL   = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [STREAM_W-1:0]       strIn,
    input  logic [N_LAYERS-1:0]       req,
    input  logic [RGB_W*N_LAYERS-1:0] layer_rgb,
    input  logic [N_LAYERS-1:0]       layer_en,
    output logic [STREAM_W-1:0]       strOut,
    output logic                      frame_tick,
    output logic [N_LAYERS-1:0]       collide
);

    localparam int IDX_W = idx_width(N_LAYERS);

    logic [N_LAYERS-1:0] en_sh;     // enables in force for the current frame
    logic                vs_prev;   // last seen vsync level
    logic                boundary;  // current input pixel opens a new frame
    logic                pix_av;
    logic [IDX_W-1:0]    sel_idx;
    logic                sel_vld;
    logic [RGB_W-1:0]    sel_rgb;
    logic [RGB_W-1:0]    pix_rgb;

    // The incoming colour bits are replaced, never forwarded.
    logic unused_in_rgb;
    assign unused_in_rgb = &{1'b0, strIn[R_POS:B_POS]};

    assign pix_av   = strIn[AV_POS];
    assign boundary = (strIn[VS_POS] == VS_POL) && (vs_prev != VS_POL);

    rgb_prio_sel #(
        .N_LAYERS (N_LAYERS),
        .IDX_W    (IDX_W)
    ) u_sel (
        .req   (req),
        .en    (en_sh),
        .idx   (sel_idx),
        .valid (sel_vld)
    );

    // Pick the winning layer colour, falling back to background; blanking
    // pixels are forced black whatever the layers request.
    always_comb begin
        sel_rgb = BG_RGB;
        for (int i = 0; i < N_LAYERS; i++) begin
            if (sel_vld && sel_idx == IDX_W'(i)) begin
                sel_rgb = layer_rgb[i*RGB_W +: RGB_W];
            end
        end
        pix_rgb = pix_av ? sel_rgb : '0;
    end

    // One-stage output pipeline: new colour, untouched position/sync bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strOut     <= '0;
            frame_tick <= 1'b0;
        end else begin
            strOut     <= {pix_rgb, strIn[META_W-1:0]};
            frame_tick <= boundary;
        end
    end

    // Vsync edge history; resets to the active level so a reset released
    // inside vsync does not produce a spurious boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_prev <= VS_POL;
        end else begin
            vs_prev <= strIn[VS_POS];
        end
    end

    // Shadow enables: layer_en is only sampled on the boundary pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_sh <= '1;
        end else if (boundary) begin
            en_sh <= layer_en;
        end
    end

`ifdef RGB_LAYER_COLLISION_EN
    logic [N_LAYERS-1:0] acc;
    logic [N_LAYERS-1:0] hit;

    // A hit is layer i overlapping layer 0 on an active pixel, counted
    // whether or not layer i wins arbitration. Bit 0 never hits.
    always_comb begin
        hit = '0;
        for (int i = 1; i < N_LAYERS; i++) begin
            hit[i] = pix_av & req[0] & en_sh[0] & req[i] & en_sh[i];
        end
    end

    // Per-frame accumulator; the boundary clear takes precedence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (boundary) begin
            acc <= '0;
        end else begin
            acc <= acc | hit;
        end
    end

    // Publish the finished frame's hits alongside frame_tick and hold them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            collide <= '0;
        end else if (boundary) begin
            collide <= acc;
        end
    end
`else
    assign collide = '0;
`endif

endmodule

// File: tb/tb_rgb_layer_arbiter.sv
// Self-checking bench for rgb_layer_arbiter: directed cases with literal
// expectations plus randomized frames compared against a behavioural model.
module tb_rgb_layer_arbiter;
    import rgb_layer_arbiter_pkg::*;

    localparam int         N  = 4;
    localparam logic [2:0] BG = 3'b011;
    localparam logic       VP = 1'b0;
    localparam logic       VI = ~VP;

    logic                clk = 1'b0;
    logic                rst;
    logic [25:0]         strIn;
    logic [N-1:0]        req;
    logic [3*N-1:0]      layer_rgb;
    logic [N-1:0]        layer_en;
    logic [25:0]         strOut;
    logic                frame_tick;
    logic [N-1:0]        collide;

    int total = 0;
    int bad   = 0;

    // Model state
    logic [N-1:0] m_en, m_acc, m_col;
    logic         m_vsp;
    logic [25:0]  e_out;
    logic         e_tick;

    rgb_layer_arbiter #(.N_LAYERS(N), .BG_RGB(BG), .VS_POL(VP)) dut (
        .clk(clk), .rst(rst), .strIn(strIn), .req(req),
        .layer_rgb(layer_rgb), .layer_en(layer_en),
        .strOut(strOut), .frame_tick(frame_tick), .collide(collide)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_en = '1; m_acc = '0; m_col = '0; m_vsp = VP;
        e_out = '0; e_tick = 1'b0;
    endtask

    // What the outputs must be after an edge that saw the current inputs.
    task automatic model_step();
        logic [2:0] c;
        logic       found, bnd;
        c = BG; found = 1'b0;
        for (int i = 0; i < N; i++)
            if (!found && req[i] && m_en[i]) begin
                c = layer_rgb[3*i +: 3];
                found = 1'b1;
            end
        if (!strIn[0]) c = 3'b000;
        e_out  = {c, strIn[22:0]};
        bnd    = (strIn[1] == VP) && (m_vsp != VP);
        e_tick = bnd;
`ifdef RGB_LAYER_COLLISION_EN
        if (bnd) begin
            m_col = m_acc;
            m_acc = '0;
        end else if (strIn[0] && req[0] && m_en[0]) begin
            m_acc = m_acc | (req & m_en & {{(N-1){1'b1}}, 1'b0});
        end
`endif
        if (bnd) m_en = layer_en;
        m_vsp = strIn[1];
    endtask

    // Drive one pixel, clock it, then compare the DUT against the model.
    task automatic cyc(input logic [25:0] s, input logic [N-1:0] rq,
                       input logic [3*N-1:0] rgb, input logic [N-1:0] en);
        strIn = s; req = rq; layer_rgb = rgb; layer_en = en;
        @(posedge clk);
        if (rst) model_reset(); else model_step();
        #1;
        chk("strOut", strOut, e_out);
        chk("frame_tick", frame_tick, e_tick);
        chk("collide", collide, m_col);
    endtask

    // Stream word with random junk in the colour field, which must be ignored.
    function automatic logic [25:0] pix(input int x, input int y, input logic hs,
                                        input logic vs, input logic av);
        logic [9:0] xx, yy;
        xx = 10'(x); yy = 10'(y);
        return {3'($urandom), xx, yy, hs, vs, av};
    endfunction

    logic [25:0]    s;
    logic [N-1:0]   en_r;

    initial begin
        rst = 1'b1; strIn = '0; req = '0; layer_rgb = '0; layer_en = '1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset strOut", strOut, 0);
        chk("reset tick", frame_tick, 0);
        chk("reset collide", collide, 0);
        rst = 1'b0;

        // Priority: layers 1 and 2 request, layer 1 wins
        s = pix(5, 3, 1'b1, VI, 1'b1);
        cyc(s, 4'b0110, {3'b111, 3'b010, 3'b100, 3'b001}, '1);
        chk("prio rgb", strOut[25:23], 3'b100);
        chk("prio meta", strOut[22:0], s[22:0]);

        // Blanking forces black; unclaimed active pixel is background
        cyc(pix(7, 3, 1'b0, VI, 1'b0), 4'b1111, 12'hfff, '1);
        chk("blank rgb", strOut[25:23], 3'b000);
        cyc(pix(8, 3, 1'b0, VI, 1'b1), 4'b0000, 12'hfff, '1);
        chk("bg rgb", strOut[25:23], BG);

        // Shadow enables: disabling layer 1 mid-frame waits for the boundary
        for (int k = 0; k < 3; k++) begin
            cyc(pix(k, 4, 1'b0, VI, 1'b1), 4'b0010, {3'b000, 3'b000, 3'b001, 3'b000}, 4'b1101);
            chk("shadow pre", strOut[25:23], 3'b001);
        end
        cyc(pix(0, 6, 1'b0, VP, 1'b0), 4'b0010, {3'b000, 3'b000, 3'b001, 3'b000}, 4'b1101);
        chk("boundary tick", frame_tick, 1);
        cyc(pix(1, 6, 1'b0, VP, 1'b0), 4'b0010, {3'b000, 3'b000, 3'b001, 3'b000}, 4'b1101);
        chk("tick one cycle", frame_tick, 0);
        cyc(pix(0, 0, 1'b0, VI, 1'b1), 4'b0010, {3'b000, 3'b000, 3'b001, 3'b000}, 4'b1101);
        chk("shadow post", strOut[25:23], BG);

        // Mid-stream asynchronous reset, then enables back to all ones
        #2 rst = 1'b1;
        #1;
        chk("async strOut", strOut, 0);
        chk("async tick", frame_tick, 0);
        chk("async collide", collide, 0);
        model_reset();
        cyc(pix(2, 0, 1'b0, VI, 1'b1), 4'b0010, 12'h008, 4'b0000);
        rst = 1'b0;
        cyc(pix(3, 0, 1'b0, VI, 1'b1), 4'b0010, 12'h008, 4'b0000);
        chk("en after reset", strOut[25:23], 3'b001);

        // Reset released inside vsync: no tick until the next rising edge
        rst = 1'b1;
        model_reset();
        cyc(pix(0, 6, 1'b0, VP, 1'b0), 4'b0000, '0, '1);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc(pix(k + 1, 6, 1'b0, VP, 1'b0), 4'b0000, '0, '1);
            chk("no tick in vs", frame_tick, 0);
        end
        cyc(pix(0, 7, 1'b0, VI, 1'b0), 4'b0000, '0, '1);
        chk("no tick vs off", frame_tick, 0);
        cyc(pix(0, 6, 1'b0, VP, 1'b0), 4'b0000, '0, '1);
        chk("tick after edge", frame_tick, 1);

        // Collision: one pixel where layers 0 and 2 overlap
        cyc(pix(1, 0, 1'b0, VI, 1'b1), 4'b0101, 12'h123, '1);
        cyc(pix(2, 0, 1'b0, VI, 1'b1), 4'b0001, 12'h123, '1);
        cyc(pix(0, 6, 1'b0, VP, 1'b0), 4'b0000, 12'h123, '1);
`ifdef RGB_LAYER_COLLISION_EN
        chk("collide hit", collide, 4'b0100);
`else
        chk("collide off", collide, 4'b0000);
`endif
        cyc(pix(1, 0, 1'b0, VI, 1'b1), 4'b0001, 12'h123, '1);
        cyc(pix(0, 6, 1'b0, VP, 1'b0), 4'b0000, 12'h123, '1);
        chk("collide clear", collide, 4'b0000);

        // Randomized frames
        en_r = '1;
        for (int f = 0; f < 15; f++)
            for (int y = 0; y < 8; y++)
                for (int x = 0; x < 10; x++) begin
                    if ($urandom_range(0, 15) == 0) en_r = N'($urandom);
                    cyc(pix(x, y, (x >= 8), (y == 6) ? VP : VI, (x < 7 && y < 5)),
                        N'($urandom), 12'($urandom), en_r);
                end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
